// File: rtl/sysbus_mem_responder.sv
// Memory-side system bus responder: 64-byte line reads returned critical-word-first with
// wrap, and 8-beat line writes followed by a one-cycle snoop-invalidate broadcast.
module sysbus_mem_responder #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       DEPTH_LINES    = 1024,
  parameter int                       READ_LATENCY   = 4,
  parameter logic [3:0]               MEM_TYPE       = 4'h1,
  parameter logic [BUS_TAG_WIDTH-1:0] INV_TAG        = 13'h0800
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respack,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, ACK, RWAIT, RDATA, WDATA, INV} state_t;
  typedef logic [7:0][BUS_DATA_WIDTH-1:0] line_t;

  state_t                    state_q, state_d;
  logic [BUS_DATA_WIDTH-7:0] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [2:0]                off_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                beat_q, beat_d;
  logic [2:0]                wcnt_q, wcnt_d;
  logic [2:0]                sel;
  logic                      accept, capture, commit, load_line, read_out;
  logic                      reqack_d, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_d;
  logic [IDX_W-1:0]          line_idx;

  line_t wbuf;
  line_t rline;
  line_t mem [DEPTH_LINES];

  assign line_idx = addr_q[IDX_W-1:0];

  // Output values are computed for the next cycle so every bus output comes from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    wcnt_d    = wcnt_q;
    accept    = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    load_line = 1'b0;
    read_out  = 1'b0;
    reqack_d  = 1'b0;
    respcyc_d = 1'b0;
    resp_d    = '0;
    resptag_d = '0;
    unique case (state_q)
      IDLE: begin
        if (bus_reqcyc && bus_reqtag[11:8] == MEM_TYPE) begin
          accept   = 1'b1;
          reqack_d = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        beat_d = '0;
        wcnt_d = '0;
        if (tag_q[BUS_TAG_WIDTH-1]) begin
          state_d = WDATA;
        end else begin
          state_d   = RWAIT;
          cnt_d     = CNT_W'(READ_LATENCY - 1);
          load_line = 1'b1;
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          state_d  = RDATA;
          read_out = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RDATA: begin
        if (bus_respack && beat_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          read_out = 1'b1;
          if (bus_respack) beat_d = beat_q + 3'd1;
        end
      end
      WDATA: begin
        if (bus_reqcyc) begin
          capture = 1'b1;
          if (wcnt_q == 3'd7) begin
            commit    = 1'b1;
            state_d   = INV;
            respcyc_d = 1'b1;
            resptag_d = INV_TAG;
            resp_d    = {addr_q, 6'b0};
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      INV:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Read beats wrap within the line starting at the requested word.
    sel = off_q + beat_d;
    if (read_out) begin
      respcyc_d = 1'b1;
      resptag_d = tag_q;
      resp_d    = rline[sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      tag_q       <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      wcnt_q      <= '0;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      wcnt_q      <= wcnt_d;
      bus_reqack  <= reqack_d;
      bus_respcyc <= respcyc_d;
      bus_resp    <= resp_d;
      bus_resptag <= resptag_d;
      if (accept) begin
        addr_q <= bus_req[BUS_DATA_WIDTH-1:6];
        tag_q  <= bus_reqtag;
        off_q  <= bus_req[5:3];
      end
    end
  end

  // Storage is never reset; a line is written only once all eight beats have arrived.
  always_ff @(posedge clk) begin
    if (capture)   wbuf[wcnt_q] <= bus_req;
    if (commit)    mem[line_idx] <= {bus_req, wbuf[6:0]};
    if (load_line) rline <= mem[line_idx];
  end

endmodule
